mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/mem_port_arbiter_wait_counter.sv | 34 +++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared types and widths for the instruction/data memory port arbiter:
// FSM state encoding, wait/streak/conflict counter widths and bus width.
package mem_port_arbiter_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WAIT_W     = 4;   // holds WAIT_CYCLES-1 for 1..15
  localparam int unsigned STREAK_W   = 3;   // data-grant streak, up to 7
  localparam int unsigned CONFLICT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch port, data port, memory side and conflict counter of the
// arbiter. slave = arbiter side, master = CPU/memory/testbench side.
//   fetch : if_req_i, if_addr_i -> if_ready_o, if_rdata_o, if_stall_o
//   data  : dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i
//           -> dm_ready_o, dm_rdata_o, dm_stall_o
//   memory: mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o <- mem_rdata_i
//   stats : conflict_cnt_o
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic                  if_req_i;
  logic [DATA_W-1:0]     if_addr_i;
  logic                  if_ready_o;
  logic [DATA_W-1:0]     if_rdata_o;
  logic                  if_stall_o;

  logic                  dm_req_i;
  logic                  dm_we_i;
  logic [DATA_W-1:0]     dm_addr_i;
  logic [DATA_W-1:0]     dm_wdata_i;
  logic                  dm_ready_o;
  logic [DATA_W-1:0]     dm_rdata_o;
  logic                  dm_stall_o;

  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [DATA_W-1:0]     mem_addr_o;
  logic [DATA_W-1:0]     mem_wdata_o;
  logic [DATA_W-1:0]     mem_rdata_i;

  logic [CONFLICT_W-1:0] conflict_cnt_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_ready_o, if_rdata_o, if_stall_o,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output dm_ready_o, dm_rdata_o, dm_stall_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i,
    output conflict_cnt_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_ready_o, if_rdata_o, if_stall_o,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  dm_ready_o, dm_rdata_o, dm_stall_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i,
    input  conflict_cnt_o
  );

endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// wait_counter
// Loadable down-counter used to time a memory access.
//   clk_i      : clock
//   rst_i      : asynchronous active-low reset
//   i_load     : load i_load_val (takes precedence over counting)
//   i_load_val : start value
//   o_done     : counter is zero
module wait_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = WAIT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_done
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the fetch port and the data port.
// Data wins ties unless MAX_D_STREAK data grants in a row have starved a
// waiting fetch. Each access occupies the memory for WAIT_CYCLES cycles and
// finishes with a one-cycle ready pulse on the owning port.
//   clk_i : clock
//   rst_i : asynchronous active-low reset
//   bus   : fetch/data/memory/statistics signals (mem_port_arbiter_if.slave)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES  = 2,
  parameter int unsigned MAX_D_STREAK = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [WAIT_W-1:0]   LP_WAIT_LOAD = WAIT_W'(WAIT_CYCLES - 1);
  localparam logic [STREAK_W-1:0] LP_STREAK    = STREAK_W'(MAX_D_STREAK);

  arb_state_t             r_state;
  logic [STREAK_W-1:0]    r_streak;
  logic [CONFLICT_W-1:0]  r_conflict_cnt;
  logic [DATA_W-1:0]      r_if_rdata;
  logic [DATA_W-1:0]      r_dm_rdata;
  logic [DATA_W-1:0]      r_mem_addr;
  logic [DATA_W-1:0]      r_mem_wdata;
  logic                   r_mem_en;
  logic                   r_mem_we;
  logic                   r_we;
  logic                   r_if_ready;
  logic                   r_dm_ready;

  logic w_fetch_wins;
  logic w_grant_d;
  logic w_grant_i;
  logic w_grant;
  logic w_both;
  logic w_wait_done;

  // A starved fetch overrides data priority once the streak limit is hit.
  assign w_fetch_wins = bus.if_req_i && (r_streak == LP_STREAK);
  assign w_grant_d    = (r_state == IDLE) && bus.dm_req_i && !w_fetch_wins;
  assign w_grant_i    = (r_state == IDLE) && bus.if_req_i && !w_grant_d;
  assign w_grant      = w_grant_d || w_grant_i;
  assign w_both       = bus.if_req_i && bus.dm_req_i;

  // Loaded with WAIT_CYCLES-1 at grant; done marks the last BUSY cycle.
  wait_counter #(.WIDTH(WAIT_W)) u_wait (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_load     (w_grant),
    .i_load_val (LP_WAIT_LOAD),
    .o_done     (w_wait_done)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state        <= IDLE;
      r_streak       <= '0;
      r_conflict_cnt <= '0;
      r_if_rdata     <= '0;
      r_dm_rdata     <= '0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_en       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_we           <= 1'b0;
      r_if_ready     <= 1'b0;
      r_dm_ready     <= 1'b0;
    end else begin
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;

      if (!bus.if_req_i || w_grant_i) begin
        r_streak <= '0;
      end else if (w_grant_d) begin
        r_streak <= r_streak + STREAK_W'(1);
      end

      if (w_grant && w_both && (r_conflict_cnt != '1)) begin
        r_conflict_cnt <= r_conflict_cnt + CONFLICT_W'(1);
      end

      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state     <= BUSY_D;
            r_mem_en    <= 1'b1;
            r_mem_addr  <= bus.dm_addr_i;
            r_we        <= bus.dm_we_i;
            r_mem_we    <= bus.dm_we_i;
            r_mem_wdata <= bus.dm_we_i ? bus.dm_wdata_i : '0;
          end else if (w_grant_i) begin
            r_state     <= BUSY_I;
            r_mem_en    <= 1'b1;
            r_mem_addr  <= bus.if_addr_i;
            r_we        <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          // Write strobe lasts only the first BUSY cycle.
          r_mem_we <= 1'b0;
          if (w_wait_done) begin
            r_state     <= IDLE;
            r_mem_en    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            if (r_state == BUSY_I) begin
              r_if_ready <= 1'b1;
              r_if_rdata <= bus.mem_rdata_i;
            end else begin
              r_dm_ready <= 1'b1;
              if (!r_we) begin
                r_dm_rdata <= bus.mem_rdata_i;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.if_ready_o     = r_if_ready;
  assign bus.if_rdata_o     = r_if_rdata;
  assign bus.if_stall_o     = bus.if_req_i && !r_if_ready;
  assign bus.dm_ready_o     = r_dm_ready;
  assign bus.dm_rdata_o     = r_dm_rdata;
  assign bus.dm_stall_o     = bus.dm_req_i && !r_dm_ready;
  assign bus.mem_en_o       = r_mem_en;
  assign bus.mem_we_o       = r_mem_we;
  assign bus.mem_addr_o     = r_mem_addr;
  assign bus.mem_wdata_o    = r_mem_wdata;
  assign bus.conflict_cnt_o = r_conflict_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench: table of isolated accesses plus hand-written conflict,
// streak, reset and saturation sequences. Ready pulses are checked against a
// per-port queue of {rdata, cycle} expectations.
module tb_mem_port_arbiter;

  localparam int unsigned WAIT   = 2;
  localparam int unsigned STREAK = 3;

  logic clk   = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if ifc();

  mem_port_arbiter #(
    .WAIT_CYCLES  (WAIT),
    .MAX_D_STREAK (STREAK)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (ifc)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    chk(name, {31'd0, got}, {31'd0, exp});
  endtask

  // ---------------- memory model ----------------
  function automatic logic [31:0] init_word(input logic [7:0] idx);
    if (idx == 8'd4) return 32'h2002000A;
    return {24'h5A5A00, idx};
  endfunction

  logic [31:0] wmem [256];
  logic        wval [256];

  always @(posedge clk) begin
    if (!rst_i) begin
      for (int i = 0; i < 256; i++) wval[i] <= 1'b0;
    end else if (ifc.mem_we_o) begin
      wmem[ifc.mem_addr_o[9:2]] <= ifc.mem_wdata_o;
      wval[ifc.mem_addr_o[9:2]] <= 1'b1;
    end
  end

  always_comb begin
    ifc.mem_rdata_i = '0;
    if (ifc.mem_en_o)
      ifc.mem_rdata_i = wval[ifc.mem_addr_o[9:2]] ? wmem[ifc.mem_addr_o[9:2]]
                                                  : init_word(ifc.mem_addr_o[9:2]);
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    int unsigned cyc;
  } sb_t;

  sb_t if_q[$];
  sb_t dm_q[$];

  int unsigned we_cnt  = 0;
  logic [31:0] we_addr = '0;
  logic [31:0] we_data = '0;

  sb_t e;
  bit  exp_i, exp_d;
  initial forever begin
    @(negedge clk);
    if (rst_i) begin
      exp_i = (if_q.size() != 0) && (if_q[0].cyc == cyc);
      if (ifc.if_ready_o || exp_i) begin
        chk1("if_ready", ifc.if_ready_o, exp_i);
        if (exp_i) begin
          e = if_q.pop_front();
          if (ifc.if_ready_o) chk("if_rdata", ifc.if_rdata_o, e.rdata);
        end
      end
      exp_d = (dm_q.size() != 0) && (dm_q[0].cyc == cyc);
      if (ifc.dm_ready_o || exp_d) begin
        chk1("dm_ready", ifc.dm_ready_o, exp_d);
        if (exp_d) begin
          e = dm_q.pop_front();
          if (ifc.dm_ready_o) chk("dm_rdata", ifc.dm_rdata_o, e.rdata);
        end
      end
      if (ifc.mem_we_o) begin
        we_cnt++;
        we_addr = ifc.mem_addr_o;
        we_data = ifc.mem_wdata_o;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic run_single(input vec_t v);
    int unsigned stall_n;
    bit          done;
    logic        st, rd;
    @(negedge clk);
    we_cnt = 0;
    if (v.is_d) begin
      ifc.dm_req_i   = 1'b1;
      ifc.dm_we_i    = v.we;
      ifc.dm_addr_i  = v.addr;
      ifc.dm_wdata_i = v.wdata;
      dm_q.push_back('{v.exp_rdata, cyc + WAIT + 1});
    end else begin
      ifc.if_req_i  = 1'b1;
      ifc.if_addr_i = v.addr;
      if_q.push_back('{v.exp_rdata, cyc + WAIT + 1});
    end
    stall_n = 0;
    done    = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin
      #1;
      st = v.is_d ? ifc.dm_stall_o : ifc.if_stall_o;
      rd = v.is_d ? ifc.dm_ready_o : ifc.if_ready_o;
      if (st) stall_n++;
      if (k == 1) begin
        chk1("busy_mem_en", ifc.mem_en_o, 1'b1);
        chk("busy_mem_addr", ifc.mem_addr_o, v.addr);
      end
      if (rd) begin
        done = 1'b1;
        chk1("idle_mem_en", ifc.mem_en_o, 1'b0);
        chk("idle_mem_addr", ifc.mem_addr_o, 32'h0);
      end else begin
        @(negedge clk);
      end
    end
    chk("stall_cycles", stall_n, WAIT + 1);
    ifc.dm_req_i = 1'b0;
    ifc.dm_we_i  = 1'b0;
    ifc.if_req_i = 1'b0;
    chk("we_pulses", we_cnt, {31'd0, v.we});
    if (v.we) begin
      chk("we_addr", we_addr, v.addr);
      chk("we_data", we_data, v.wdata);
    end
  endtask

  // Both ports request reads together; each drops its request on its ready.
  task automatic run_conflict(input logic [31:0] iaddr, input logic [31:0] iexp,
                              input logic [31:0] daddr, input logic [31:0] dexp);
    @(negedge clk);
    ifc.if_req_i  = 1'b1;
    ifc.if_addr_i = iaddr;
    ifc.dm_req_i  = 1'b1;
    ifc.dm_we_i   = 1'b0;
    ifc.dm_addr_i = daddr;
    dm_q.push_back('{dexp, cyc + WAIT + 1});
    if_q.push_back('{iexp, cyc + 2 * (WAIT + 1)});
    for (int k = 0; k < 20 && (ifc.if_req_i || ifc.dm_req_i); k++) begin
      @(negedge clk);
      #1;
      if (ifc.dm_ready_o) ifc.dm_req_i = 1'b0;
      if (ifc.if_ready_o) ifc.if_req_i = 1'b0;
    end
    chk1("conflict_done", ifc.if_req_i || ifc.dm_req_i, 1'b0);
    ifc.if_req_i = 1'b0;
    ifc.dm_req_i = 1'b0;
  endtask

  vec_t vecs [8];
  logic [15:0] exp_cnt;
  int unsigned i_seen;

  initial begin
    ifc.if_req_i   = 1'b0;
    ifc.if_addr_i  = '0;
    ifc.dm_req_i   = 1'b0;
    ifc.dm_we_i    = 1'b0;
    ifc.dm_addr_i  = '0;
    ifc.dm_wdata_i = '0;

    vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        32'h2002000A};
    vecs[1] = '{1'b1, 1'b0, 32'h40,  32'h0,        32'h5A5A0010};
    vecs[2] = '{1'b1, 1'b1, 32'h80,  32'hDEADBEEF, 32'h5A5A0010};
    vecs[3] = '{1'b1, 1'b0, 32'h80,  32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b0, 32'h04,  32'h0,        32'h5A5A0001};
    vecs[5] = '{1'b1, 1'b0, 32'h00,  32'h0,        32'h5A5A0000};
    vecs[6] = '{1'b0, 1'b0, 32'h80,  32'h0,        32'hDEADBEEF};
    vecs[7] = '{1'b1, 1'b1, 32'h84,  32'h12345678, 32'h5A5A0000};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_mem_en", ifc.mem_en_o, 1'b0);
    chk1("rst_mem_we", ifc.mem_we_o, 1'b0);
    chk1("rst_if_ready", ifc.if_ready_o, 1'b0);
    chk1("rst_dm_ready", ifc.dm_ready_o, 1'b0);
    chk("rst_conflict", {16'd0, ifc.conflict_cnt_o}, 32'd0);
    chk("rst_dm_rdata", ifc.dm_rdata_o, 32'd0);
    @(posedge clk);
    #1 rst_i = 1'b1;

    // isolated accesses; the first is sampled on the first edge after reset
    for (int n = 0; n < 8; n++) run_single(vecs[n]);
    chk("no_conflicts_yet", {16'd0, ifc.conflict_cnt_o}, 32'd0);

    // simultaneous fetch 0x04 and load 0x40: data first
    run_conflict(32'h04, 32'h5A5A0001, 32'h40, 32'h5A5A0010);
    chk("conflict_cnt_1", {16'd0, ifc.conflict_cnt_o}, 32'd1);

    // both held: grant order D,D,D,I,D,D,D,I
    @(negedge clk);
    ifc.if_req_i  = 1'b1;
    ifc.if_addr_i = 32'h10;
    ifc.dm_req_i  = 1'b1;
    ifc.dm_we_i   = 1'b0;
    ifc.dm_addr_i = 32'h40;
    for (int g = 0; g < 8; g++) begin
      if ((g % (STREAK + 1)) == STREAK)
        if_q.push_back('{32'h2002000A, cyc + (WAIT + 1) * (g + 1)});
      else
        dm_q.push_back('{32'h5A5A0010, cyc + (WAIT + 1) * (g + 1)});
    end
    i_seen = 0;
    for (int k = 0; k < 40 && i_seen < 2; k++) begin
      @(negedge clk);
      #1;
      if (ifc.if_ready_o) i_seen++;
    end
    ifc.if_req_i = 1'b0;
    ifc.dm_req_i = 1'b0;
    chk("streak_fetches", i_seen, 32'd2);
    chk("conflict_cnt_9", {16'd0, ifc.conflict_cnt_o}, 32'd9);

    // reset in the second BUSY_D cycle
    @(negedge clk);
    ifc.dm_req_i  = 1'b1;
    ifc.dm_we_i   = 1'b0;
    ifc.dm_addr_i = 32'h100;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk1("pre_rst_busy", ifc.mem_en_o, 1'b1);
    ifc.dm_req_i = 1'b0;
    rst_i = 1'b0;
    #1;
    chk1("arst_mem_en", ifc.mem_en_o, 1'b0);
    chk1("arst_mem_we", ifc.mem_we_o, 1'b0);
    chk("arst_mem_addr", ifc.mem_addr_o, 32'd0);
    chk("arst_mem_wdata", ifc.mem_wdata_o, 32'd0);
    chk1("arst_dm_ready", ifc.dm_ready_o, 1'b0);
    chk1("arst_if_ready", ifc.if_ready_o, 1'b0);
    chk("arst_if_rdata", ifc.if_rdata_o, 32'd0);
    chk("arst_dm_rdata", ifc.dm_rdata_o, 32'd0);
    chk("arst_conflict", {16'd0, ifc.conflict_cnt_o}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk1("no_ready_after_rst", ifc.dm_ready_o, 1'b0);
    end
    run_single('{1'b1, 1'b0, 32'h100, 32'h0, 32'h5A5A0040});

    // saturation: preload near the top, then keep conflicting
    @(negedge clk);
    force dut.r_conflict_cnt = 16'hFFFD;
    #1;
    release dut.r_conflict_cnt;
    exp_cnt = 16'hFFFD;
    chk("sat_preload", {16'd0, ifc.conflict_cnt_o}, {16'd0, exp_cnt});
    for (int n = 0; n < 4; n++) begin
      run_conflict(32'h04, 32'h5A5A0001, 32'h40, 32'h5A5A0010);
      exp_cnt = (exp_cnt == 16'hFFFF) ? 16'hFFFF : exp_cnt + 16'd1;
      chk("sat_conflict", {16'd0, ifc.conflict_cnt_o}, {16'd0, exp_cnt});
    end

    repeat (4) @(negedge clk);
    chk("sb_if_drained", if_q.size(), 32'd0);
    chk("sb_dm_drained", dm_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
